// File: rtl/reply_encoder.sv
// Reply frame encoder: snapshots a decoded command and its register values, then
// streams header, cmd echo and payload bytes to a UART transmitter one byte at a time.
// Optional trailing XOR checksum byte when REPLY_CHECKSUM_EN is defined.
module reply_encoder #(
    parameter int         DATA_BIT   = 32,
    parameter logic [7:0] ACK_HDR    = 8'h55,
    parameter logic [7:0] NAK_HDR    = 8'hEE,
    parameter logic [7:0] CMD_DATA   = 8'h01,
    parameter logic [7:0] CMD_FREQ   = 8'h02,
    parameter logic [7:0] CMD_PERIOD = 8'h03,
    parameter logic [7:0] CMD_CTRL   = 8'h04,
    parameter logic [7:0] CMD_REPEAT = 8'h05
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic [7:0]          cmd_i,
    input  logic                done_tick_i,
    input  logic [7:0]          sel_out_i,
    input  logic [1:0]          mode_i,
    input  logic                enable_i,
    input  logic [7:0]          repeat_i,
    input  logic [7:0]          slow_period_i,
    input  logic [7:0]          fast_period_i,
    input  logic [DATA_BIT-1:0] output_pattern_i,
    input  logic [DATA_BIT-1:0] freq_pattern_i,
    output logic                tx_start_o,
    output logic [7:0]          tx_data_o,
    input  logic                tx_done_tick_i,
    output logic                busy_o,
    output logic                frame_done_tick_o,
    output logic                drop_tick_o
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    typedef struct packed {
        logic [7:0]          cmd;
        logic [7:0]          sel;
        logic [1:0]          mode;
        logic                enable;
        logic [7:0]          rpt;
        logic [7:0]          slow;
        logic [7:0]          fast;
        logic [DATA_BIT-1:0] pattern;
        logic [DATA_BIT-1:0] freq;
    } snap_t;

    state_t          state_q, state_d;
    snap_t           snap_q;
    logic [3:0]      idx_q;
    logic            drop_q;

    logic [7:0]      hdr;
    logic [4:0][7:0] pl;
    logic [3:0]      pl_len;
    logic [3:0]      frame_len;
    logic [3:0]      last_idx;
    logic [7:0]      cur_byte;

    logic            capture;
    logic            advance;

    assign capture = (state_q == IDLE) && done_tick_i;
    assign advance = (state_q == WAIT) && tx_done_tick_i;

    // Payload bytes and length are derived from the snapshot, so they cannot move mid-frame.
    always_comb begin
        hdr    = ACK_HDR;
        pl     = '0;
        pl_len = 4'd0;
        case (snap_q.cmd)
            CMD_DATA: begin
                pl     = {snap_q.pattern[31:24], snap_q.pattern[23:16],
                          snap_q.pattern[15:8],  snap_q.pattern[7:0], snap_q.sel};
                pl_len = 4'd5;
            end
            CMD_FREQ: begin
                pl     = {8'h00, snap_q.freq[31:24], snap_q.freq[23:16],
                          snap_q.freq[15:8], snap_q.freq[7:0]};
                pl_len = 4'd4;
            end
            CMD_PERIOD: begin
                pl     = {24'h0, snap_q.fast, snap_q.slow};
                pl_len = 4'd2;
            end
            CMD_CTRL: begin
                pl     = {24'h0, 5'h0, snap_q.mode, snap_q.enable, snap_q.sel};
                pl_len = 4'd2;
            end
            CMD_REPEAT: begin
                pl     = {24'h0, snap_q.rpt, snap_q.sel};
                pl_len = 4'd2;
            end
            default: hdr = NAK_HDR;
        endcase
    end

`ifdef REPLY_CHECKSUM_EN
    logic [7:0] csum_q;

    assign frame_len = 4'd3 + pl_len;

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n)
            csum_q <= 8'h00;
        else if (capture)
            csum_q <= 8'h00;
        else if (advance)
            csum_q <= csum_q ^ cur_byte;
    end
`else
    assign frame_len = 4'd2 + pl_len;
`endif

    assign last_idx = frame_len - 4'd1;

    always_comb begin
        case (idx_q)
            4'd0:    cur_byte = hdr;
            4'd1:    cur_byte = snap_q.cmd;
            4'd2:    cur_byte = pl[0];
            4'd3:    cur_byte = pl[1];
            4'd4:    cur_byte = pl[2];
            4'd5:    cur_byte = pl[3];
            4'd6:    cur_byte = pl[4];
            default: cur_byte = 8'h00;
        endcase
`ifdef REPLY_CHECKSUM_EN
        if (idx_q == last_idx)
            cur_byte = csum_q;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (done_tick_i) state_d = SEND;
            SEND:    state_d = WAIT;
            WAIT:    if (tx_done_tick_i) state_d = (idx_q == last_idx) ? DONE : SEND;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_start_o        = (state_q == SEND);
        busy_o            = (state_q != IDLE);
        frame_done_tick_o = (state_q == DONE);
        tx_data_o         = (state_q == SEND || state_q == WAIT) ? cur_byte : 8'h00;
        drop_tick_o       = drop_q;
    end

    // Snapshot, byte index and drop strobe.
    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            snap_q <= '0;
            idx_q  <= 4'd0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= done_tick_i && (state_q != IDLE);
            if (capture) begin
                snap_q.cmd     <= cmd_i;
                snap_q.sel     <= sel_out_i;
                snap_q.mode    <= mode_i;
                snap_q.enable  <= enable_i;
                snap_q.rpt     <= repeat_i;
                snap_q.slow    <= slow_period_i;
                snap_q.fast    <= fast_period_i;
                snap_q.pattern <= output_pattern_i;
                snap_q.freq    <= freq_pattern_i;
                idx_q          <= 4'd0;
            end else if (advance && idx_q != last_idx) begin
                idx_q <= idx_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_reply_encoder.sv
// Directed bench for reply_encoder: hand-computed frames checked byte by byte,
// plus input-change, drop, stray tx_done and mid-frame reset scenarios.
module tb_reply_encoder;

    localparam logic [7:0] C_DATA   = 8'h01;
    localparam logic [7:0] C_FREQ   = 8'h02;
    localparam logic [7:0] C_PERIOD = 8'h03;
    localparam logic [7:0] C_CTRL   = 8'h04;
    localparam logic [7:0] C_REPEAT = 8'h05;
`ifdef REPLY_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  cmd_i = 8'h00;
    logic        done_tick_i = 1'b0;
    logic [7:0]  sel_out_i = 8'h00;
    logic [1:0]  mode_i = 2'b00;
    logic        enable_i = 1'b0;
    logic [7:0]  repeat_i = 8'h00;
    logic [7:0]  slow_period_i = 8'h00;
    logic [7:0]  fast_period_i = 8'h00;
    logic [31:0] output_pattern_i = 32'h0;
    logic [31:0] freq_pattern_i = 32'h0;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;
    logic        tx_done_tick_i = 1'b0;
    logic        busy_o;
    logic        frame_done_tick_o;
    logic        drop_tick_o;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_b [8];
    int         exp_n;

    reply_encoder #(
        .DATA_BIT(32), .ACK_HDR(8'h55), .NAK_HDR(8'hEE),
        .CMD_DATA(C_DATA), .CMD_FREQ(C_FREQ), .CMD_PERIOD(C_PERIOD),
        .CMD_CTRL(C_CTRL), .CMD_REPEAT(C_REPEAT)
    ) dut (
        .clk_i(clk_i), .rst_n(rst_n), .cmd_i(cmd_i), .done_tick_i(done_tick_i),
        .sel_out_i(sel_out_i), .mode_i(mode_i), .enable_i(enable_i), .repeat_i(repeat_i),
        .slow_period_i(slow_period_i), .fast_period_i(fast_period_i),
        .output_pattern_i(output_pattern_i), .freq_pattern_i(freq_pattern_i),
        .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_done_tick_i(tx_done_tick_i),
        .busy_o(busy_o), .frame_done_tick_o(frame_done_tick_o), .drop_tick_o(drop_tick_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        @(negedge clk_i);
        done_tick_i = 1'b1;
        @(negedge clk_i);
        done_tick_i = 1'b0;
    endtask

    // Plays the transmitter for exp_b[0..exp_n-1]; gap = idle cycles before each tx_done.
    task automatic run_frame(input int gap, input int drop_at, input int chg_at);
        for (int i = 0; i < exp_n; i++) begin
            for (int k = 0; k < 10 && tx_start_o !== 1'b1; k++) @(negedge clk_i);
            chk("start_seen", tx_start_o, 1);
            chk($sformatf("byte%0d", i), tx_data_o, exp_b[i]);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk_i);
                if (i == chg_at && g == 0) begin
                    sel_out_i = 8'hA5; mode_i = 2'b10; enable_i = 1'b0; repeat_i = 8'h99;
                    slow_period_i = 8'h77; fast_period_i = 8'h66;
                    output_pattern_i = 32'h01020304; freq_pattern_i = 32'h0A0B0C0D;
                    cmd_i = 8'hFF;
                end
                chk("start_one_cycle", tx_start_o, 0);
                chk("data_hold", tx_data_o, exp_b[i]);
                chk("busy_mid", busy_o, 1);
                chk("no_early_done", frame_done_tick_o, 0);
                if (i == drop_at) begin
                    if (g == 0) done_tick_i = 1'b1;
                    if (g == 1) begin chk("drop_pulse", drop_tick_o, 1); done_tick_i = 1'b0; end
                    if (g == 2) chk("drop_single", drop_tick_o, 0);
                end
            end
            tx_done_tick_i = 1'b1;
            @(negedge clk_i);
            tx_done_tick_i = 1'b0;
        end
        chk("frame_done", frame_done_tick_o, 1);
        chk("busy_done", busy_o, 1);
        @(negedge clk_i);
        chk("frame_done_once", frame_done_tick_o, 0);
        chk("busy_idle", busy_o, 0);
        chk("data_idle", tx_data_o, 8'h00);
    endtask

    initial begin
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_start", tx_start_o, 0);
        chk("rst_data", tx_data_o, 8'h00);
        chk("rst_fdone", frame_done_tick_o, 0);
        chk("rst_drop", drop_tick_o, 0);
        @(negedge clk_i);
        rst_n = 1'b0;

        // Stray tx_done in IDLE is ignored
        @(negedge clk_i);
        tx_done_tick_i = 1'b1;
        @(negedge clk_i);
        tx_done_tick_i = 1'b0;
        chk("stray_txdone_busy", busy_o, 0);
        chk("stray_txdone_start", tx_start_o, 0);

        // PERIOD
        cmd_i = C_PERIOD; slow_period_i = 8'h14; fast_period_i = 8'h05;
        exp_b = '{8'h55, C_PERIOD, 8'h14, 8'h05, 8'h47, 8'h00, 8'h00, 8'h00};
        exp_n = 4 + CS;
        start_frame();
        run_frame(2, -1, -1);

        // DATA, with a second done_tick during WAIT
        cmd_i = C_DATA; sel_out_i = 8'h05; output_pattern_i = 32'hBBCCDDEE;
        exp_b = '{8'h55, C_DATA, 8'h05, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'h15};
        exp_n = 7 + CS;
        start_frame();
        run_frame(3, 2, -1);

        // CTRL, inputs scrambled after capture
        cmd_i = C_CTRL; sel_out_i = 8'h05; mode_i = 2'b01; enable_i = 1'b1;
        exp_b = '{8'h55, C_CTRL, 8'h05, 8'h03, 8'h57, 8'h00, 8'h00, 8'h00};
        exp_n = 4 + CS;
        start_frame();
        run_frame(2, -1, 0);

        // FREQ
        cmd_i = C_FREQ; freq_pattern_i = 32'h12345678;
        exp_b = '{8'h55, C_FREQ, 8'h78, 8'h56, 8'h34, 8'h12, 8'h5F, 8'h00};
        exp_n = 6 + CS;
        start_frame();
        run_frame(1, -1, -1);

        // Unknown command -> NAK
        cmd_i = 8'hFF;
        exp_b = '{8'hEE, 8'hFF, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_n = 2 + CS;
        start_frame();
        run_frame(1, -1, -1);

        // Reset while waiting for tx_done on the first byte
        cmd_i = C_DATA; sel_out_i = 8'h05; output_pattern_i = 32'hBBCCDDEE;
        start_frame();
        chk("pre_rst_start", tx_start_o, 1);
        @(negedge clk_i);
        chk("pre_rst_busy", busy_o, 1);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_start", tx_start_o, 0);
        chk("mid_rst_data", tx_data_o, 8'h00);
        chk("mid_rst_fdone", frame_done_tick_o, 0);
        chk("mid_rst_drop", drop_tick_o, 0);
        @(negedge clk_i);
        rst_n = 1'b0;
        tx_done_tick_i = 1'b1;
        @(negedge clk_i);
        tx_done_tick_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            chk("post_rst_no_start", tx_start_o, 0);
            chk("post_rst_idle", busy_o, 0);
        end

        // REPEAT frame after recovery
        cmd_i = C_REPEAT; sel_out_i = 8'h0A; repeat_i = 8'h07;
        exp_b = '{8'h55, C_REPEAT, 8'h0A, 8'h07, 8'h5D, 8'h00, 8'h00, 8'h00};
        exp_n = 4 + CS;
        start_frame();
        run_frame(2, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reply_encoder.md
REPLY_ENCODER -- requirements
Module: reply_encoder

Interface
REQ-001 Parameter DATA_BIT, default 32, width of data/frequency patterns; SHALL be 32 (4 payload bytes).
REQ-002 Parameter ACK_HDR, default 8'h55, header byte for a recognised command.
REQ-003 Parameter NAK_HDR, default 8'hEE, header byte for an unrecognised command.
REQ-004 clk_i  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-high.
REQ-006 cmd_i, done_tick_i  input  8/1  decoded command and its one-cycle completion strobe from the decoder.
REQ-007 sel_out_i, mode_i, enable_i, repeat_i, slow_period_i, fast_period_i  input  8/2/1/8/8/8  current decoder register values.
REQ-008 output_pattern_i, freq_pattern_i  input  DATA_BIT  current data and frequency patterns.
REQ-009 tx_start_o, tx_data_o  output  1/8  one-cycle byte start strobe and byte to the UART transmitter.
REQ-010 tx_done_tick_i  input  1  UART transmitter byte-complete strobe.
REQ-011 busy_o, frame_done_tick_o, drop_tick_o  output  1/1/1  frame in progress; one-cycle end-of-frame; one-cycle rejected request.

Function
REQ-012 Frame = header, cmd echo, payload, optional checksum (REQ-027); bytes sent strictly in that order.
REQ-013 Payload per cmd_i: CMD_DATA -> sel_out, pattern[7:0], [15:8], [23:16], [31:24]; CMD_FREQ -> freq[7:0]..[31:24]; CMD_PERIOD -> slow, fast; CMD_CTRL -> sel_out, {5'h0,mode,enable}; CMD_REPEAT -> sel_out, repeat.
REQ-014 Any other cmd_i SHALL use NAK_HDR and an empty payload; recognised commands use ACK_HDR.
REQ-015 States: IDLE, SEND, WAIT, DONE.
REQ-016 IDLE: done_tick_i=1 SHALL snapshot cmd_i and all value inputs into internal registers in that cycle, set byte count, go to SEND.
REQ-017 SEND: assert tx_start_o for exactly one cycle with tx_data_o = current byte, go to WAIT; first tx_start_o is the cycle after the capturing done_tick_i.
REQ-018 WAIT: hold tx_data_o stable; on tx_done_tick_i advance index and go to SEND, or to DONE if last byte sent.
REQ-019 DONE: pulse frame_done_tick_o for one cycle, return to IDLE.
REQ-020 Snapshot values SHALL be transmitted even if inputs change mid-frame.
REQ-021 busy_o=1 in every state except IDLE.
REQ-022 done_tick_i while not in IDLE (including same cycle as final tx_done_tick_i or DONE) SHALL be ignored and produce drop_tick_o one cycle later.
REQ-023 tx_done_tick_i outside WAIT SHALL be ignored.
REQ-024 Byte index 4 bits; maximum frame length 8 bytes; no wrap beyond frame end.

Reset
REQ-025 rst_n=1 SHALL force IDLE, tx_start_o=0, tx_data_o=8'h00, busy_o=0, frame_done_tick_o=0, drop_tick_o=0, snapshot registers and index to 0, immediately and asynchronously.
REQ-026 Reset mid-frame SHALL abort the frame; no further tx_start_o until a new done_tick_i after release.

Configuration
REQ-027 Macro REPLY_CHECKSUM_EN defined: a final byte equal to XOR of all preceding frame bytes (header included) SHALL be appended; undefined: no checksum byte, frame ends after payload.

Verification
REQ-028 CMD_PERIOD, slow 8'h14, fast 8'h05 -> bytes 55, CMD_PERIOD, 14, 05 (+ 55^CMD_PERIOD^14^05 with checksum); frame_done_tick_o once.
REQ-029 CMD_DATA, sel 8'h05, pattern 32'hBBCCDDEE -> 55, CMD_DATA, 05, EE, DD, CC, BB (+XOR); tx_start_o only after each tx_done_tick_i.
REQ-030 CMD_CTRL, sel 8'h05, mode 2'b01, enable 1 -> 55, CMD_CTRL, 05, 03; change inputs mid-frame -> bytes unchanged.
REQ-031 cmd_i 8'hFF -> EE, FF (+ EE^FF=11 with checksum); busy_o low after frame_done_tick_o.
REQ-032 Second done_tick_i during WAIT -> drop_tick_o one pulse, frame unaffected; reset during WAIT -> IDLE, outputs at reset values, no further tx_start_o.
